// File: rtl/sel_estado.sv
// Two-button state selector: synchronized, debounced up/down pushbuttons step a 2-bit state code.
// Define SEL_ESTADO_SAT_EN to make est saturate at 2'b00/2'b11 instead of wrapping.
module sel_estado #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rest,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [1:0] est,
  output logic       cambio
);

  // The counter leaves an ESP state on the cycle it would reach DEB_CYCLES.
  localparam logic [23:0] CNT_LAST = 24'(DEB_CYCLES - 1);

`ifdef SEL_ESTADO_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    SUELTO   = 2'b00,
    ESP_ALTO = 2'b01,
    PULSADO  = 2'b10,
    ESP_BAJO = 2'b11
  } deb_state_t;

  logic [1:0] raw;
  logic [1:0] press;

  assign raw = {btn_dn, btn_up};

  // Index 0 is the up button, index 1 the down button.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic       sync1_reg;
      logic       sync2_reg;
      deb_state_t state_reg;
      logic [23:0] cnt_reg;
      logic       press_reg;

      always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          state_reg <= SUELTO;
          cnt_reg   <= '0;
          press_reg <= 1'b0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          case (state_reg)
            SUELTO: begin
              if (sync2_reg) begin
                state_reg <= ESP_ALTO;
                cnt_reg   <= 24'd1;
              end
            end
            ESP_ALTO: begin
              if (!sync2_reg) begin
                state_reg <= SUELTO;
                cnt_reg   <= '0;
              end else if (cnt_reg == CNT_LAST) begin
                state_reg <= PULSADO;
                cnt_reg   <= '0;
                press_reg <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + 24'd1;
              end
            end
            PULSADO: begin
              if (!sync2_reg) begin
                state_reg <= ESP_BAJO;
                cnt_reg   <= 24'd1;
              end
            end
            ESP_BAJO: begin
              if (sync2_reg) begin
                state_reg <= PULSADO;
                cnt_reg   <= '0;
              end else if (cnt_reg == CNT_LAST) begin
                state_reg <= SUELTO;
                cnt_reg   <= '0;
              end else begin
                cnt_reg <= cnt_reg + 24'd1;
              end
            end
            default: begin
              state_reg <= SUELTO;
              cnt_reg   <= '0;
            end
          endcase
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic [1:0] est_reg;
  logic       cambio_reg;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      est_reg    <= 2'b00;
      cambio_reg <= 1'b0;
    end else begin
      cambio_reg <= 1'b0;
      case (press)
        2'b01: begin
          if (!(SAT_EN && est_reg == 2'b11)) begin
            est_reg    <= est_reg + 2'd1;
            cambio_reg <= 1'b1;
          end
        end
        2'b10: begin
          if (!(SAT_EN && est_reg == 2'b00)) begin
            est_reg    <= est_reg - 2'd1;
            cambio_reg <= 1'b1;
          end
        end
        // Simultaneous presses cancel out.
        default: ;
      endcase
    end
  end

  assign est    = est_reg;
  assign cambio = cambio_reg;

endmodule

// File: tb/tb_sel_estado.sv
// Directed bench for sel_estado with DEB_CYCLES=4: reset, press table, bounce, reset mid-press.
// Expectations follow SEL_ESTADO_SAT_EN when it is defined for the build.
module tb_sel_estado;

  logic       clk;
  logic       rest;
  logic       btn_up;
  logic       btn_dn;
  logic [1:0] est;
  logic       cambio;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sel_estado #(.DEB_CYCLES(4)) dut (
    .clk    (clk),
    .rest   (rest),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .est    (est),
    .cambio (cambio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       up;
    logic       dn;
    logic [1:0] exp_est;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Hold the given buttons 14 cycles, expecting the step on edge 7, then release 10 cycles.
  task automatic press(input vec_t v);
    logic [1:0] start;
    int         pulses;
    start  = est;
    pulses = 0;
    btn_up = v.up;
    btn_dn = v.dn;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (cambio === 1'b1) pulses++;
      if (k < 7) begin
        chk({v.name, "_early_est"}, 32'(est), 32'(start));
        chk({v.name, "_early_cambio"}, 32'(cambio), 32'd0);
      end else if (k == 7) begin
        chk({v.name, "_edge7_est"}, 32'(est), 32'(v.exp_est));
        chk({v.name, "_edge7_cambio"}, 32'(cambio), 32'(v.exp_est != start));
      end else begin
        chk({v.name, "_held_est"}, 32'(est), 32'(v.exp_est));
      end
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (cambio === 1'b1) pulses++;
    end
    chk({v.name, "_release_est"}, 32'(est), 32'(v.exp_est));
    chk({v.name, "_pulses"}, 32'(pulses), 32'(v.exp_est != start));
    $display("press %-6s up=%0b dn=%0b est %0d -> %0d pulses=%0d", v.name, v.up, v.dn, start, est, pulses);
  endtask

  task automatic do_reset();
    rest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_est", 32'(est), 32'd0);
      chk("rst_cambio", 32'(cambio), 32'd0);
    end
    rest = 1'b1;
  endtask

  initial begin
`ifdef SEL_ESTADO_SAT_EN
    vecs[0] = '{"up1",  1'b1, 1'b0, 2'b01};
    vecs[1] = '{"up2",  1'b1, 1'b0, 2'b10};
    vecs[2] = '{"up3",  1'b1, 1'b0, 2'b11};
    vecs[3] = '{"upsat", 1'b1, 1'b0, 2'b11};
    vecs[4] = '{"dn1",  1'b0, 1'b1, 2'b10};
    vecs[5] = '{"dn2",  1'b0, 1'b1, 2'b01};
    vecs[6] = '{"both", 1'b1, 1'b1, 2'b01};
    vecs[7] = '{"dn3",  1'b0, 1'b1, 2'b00};
    vecs[8] = '{"dnsat", 1'b0, 1'b1, 2'b00};
`else
    vecs[0] = '{"up1",  1'b1, 1'b0, 2'b01};
    vecs[1] = '{"up2",  1'b1, 1'b0, 2'b10};
    vecs[2] = '{"up3",  1'b1, 1'b0, 2'b11};
    vecs[3] = '{"upwrap", 1'b1, 1'b0, 2'b00};
    vecs[4] = '{"dnwrap", 1'b0, 1'b1, 2'b11};
    vecs[5] = '{"dn1",  1'b0, 1'b1, 2'b10};
    vecs[6] = '{"both", 1'b1, 1'b1, 2'b10};
    vecs[7] = '{"dn2",  1'b0, 1'b1, 2'b01};
    vecs[8] = '{"dn3",  1'b0, 1'b1, 2'b00};
`endif

    rest   = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    #1;
    chk("async_rst_est", 32'(est), 32'd0);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_est", 32'(est), 32'd0);
      chk("idle_cambio", 32'(cambio), 32'd0);
    end
    $display("reset  est=%0d cambio=%0b", est, cambio);

    for (int i = 0; i < 9; i++) press(vecs[i]);

    // Bounce: 1,0,1,0 on successive cycles, final rise held; step 7 edges after it.
    do_reset();
    btn_up = 1'b1; tick();
    btn_up = 1'b0; tick();
    btn_up = 1'b1; tick();
    btn_up = 1'b0; tick();
    btn_up = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("bounce_early_est", 32'(est), 32'd0);
      chk("bounce_early_cambio", 32'(cambio), 32'd0);
    end
    tick();
    chk("bounce_step_est", 32'(est), 32'd1);
    chk("bounce_step_cambio", 32'(cambio), 32'd1);
    tick();
    chk("bounce_after_cambio", 32'(cambio), 32'd0);
    btn_up = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    $display("bounce est=%0d", est);

    // Reset mid-press: low at edge 3, released after edge 5 with the button held.
    do_reset();
    btn_up = 1'b1;
    tick();
    tick();
    rest = 1'b0;
    #1;
    chk("midrst_est", 32'(est), 32'd0);
    for (int k = 3; k <= 5; k++) begin
      tick();
      chk("midrst_in_reset_est", 32'(est), 32'd0);
    end
    rest = 1'b1;
    for (int k = 6; k <= 11; k++) begin
      tick();
      chk("midrst_early_est", 32'(est), 32'd0);
      chk("midrst_early_cambio", 32'(cambio), 32'd0);
    end
    tick();
    chk("midrst_edge12_est", 32'(est), 32'd1);
    chk("midrst_edge12_cambio", 32'(cambio), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("midrst_hold_est", 32'(est), 32'd1);
    end
    btn_up = 1'b0;
    $display("midrst est=%0d", est);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
